// File: rtl/proximity_scanner.sv
// Time-multiplexed IR proximity sensor scanner: powers one sensor at a time,
// samples it after a settle delay and debounces each channel across scans.
//
//   state  | meaning
//   IDLE   | no channel powered, waiting for run with a non-empty mask
//   SETTLE | enable[ch] high, settle down-counter running
//   SAMPLE | enable[ch] high, synchronized pin[ch] fed to the debouncer
//   GAP    | all enables low, choose next channel / end of pass
module proximity_scanner #(
  parameter int N_SENSORS     = 4,
  parameter int SETTLE_CYCLES = 1200,
  parameter int DEBOUNCE      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [N_SENSORS-1:0] mask,
  input  logic [N_SENSORS-1:0] pin,
  output logic [N_SENSORS-1:0] enable,
  output logic [N_SENSORS-1:0] detect,
  output logic                 changed,
  output logic                 scan_done,
  output logic                 busy
);

  localparam int CH_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, GAP} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch, ch_nxt;
  logic [SC_W-1:0]     settle_cnt;
  logic                settle_ld;
  logic [N_SENSORS-1:0] pin_s1, pin_s2;
  logic [DB_W-1:0]     db_cnt [N_SENSORS];

  logic                first_found, next_found;
  logic [CH_W-1:0]     first_ch, next_ch;

  // Downward loops leave the lowest qualifying index in the result.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (mask[i] && (i > int'(ch))) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    settle_ld = 1'b0;
    scan_done = 1'b0;
    case (state)
      IDLE: begin
        if (run && first_found) begin
          state_nxt = SETTLE;
          ch_nxt    = first_ch;
          settle_ld = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = SAMPLE;
      end
      SAMPLE: state_nxt = GAP;
      GAP: begin
        if (!first_found) begin
          state_nxt = IDLE;
        end else if (next_found) begin
          if (run) begin
            state_nxt = SETTLE;
            ch_nxt    = next_ch;
            settle_ld = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          scan_done = 1'b1;
          if (run) begin
            state_nxt = SETTLE;
            ch_nxt    = first_ch;
            settle_ld = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enable = '0;
    if (state == SETTLE || state == SAMPLE) enable[ch] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      settle_cnt <= '0;
      pin_s1     <= '0;
      pin_s2     <= '0;
      detect     <= '0;
      changed    <= 1'b0;
      db_cnt     <= '{default: '0};
    end else begin
      pin_s1  <= pin;
      pin_s2  <= pin_s1;
      state   <= state_nxt;
      ch      <= ch_nxt;
      changed <= 1'b0;
      if (settle_ld)
        settle_cnt <= SC_W'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SC_W'(1);
      // Counter only advances while the sample disagrees with the published level.
      if (state == SAMPLE) begin
        if (pin_s2[ch] == detect[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == DB_W'(DEBOUNCE - 1)) begin
          detect[ch] <= pin_s2[ch];
          db_cnt[ch] <= '0;
          changed    <= 1'b1;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_proximity_scanner.sv
// Bench for proximity_scanner: directed scenarios then random stimulus, all
// outputs compared each cycle against a slot-position reference model.
module tb_proximity_scanner;

  localparam int N   = 4;
  localparam int S   = 4;
  localparam int DEB = 2;

  logic         clk = 1'b0;
  logic         rst, run;
  logic [N-1:0] mask, pin;
  logic [N-1:0] enable, detect;
  logic         changed, scan_done, busy;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  proximity_scanner #(.N_SENSORS(N), .SETTLE_CYCLES(S), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .run(run), .mask(mask), .pin(pin),
    .enable(enable), .detect(detect), .changed(changed),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a channel slot is S+2 cycles; position 0..S-1 settle,
  // S is the sample cycle, S+1 the gap.
  bit           m_active = 1'b0;
  int           m_ch = 0;
  int           m_pos = 0;
  logic [N-1:0] m_det = '0, m_s1 = '0, m_s2 = '0;
  int           m_cnt [N];
  bit           m_chg = 1'b0;

  function automatic int lowest(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_above(input logic [N-1:0] m, input int c);
    for (int i = c + 1; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      m_active = 1'b0; m_ch = 0; m_pos = 0;
      m_det = '0; m_s1 = '0; m_s2 = '0; m_chg = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_chg = 1'b0;
      if (!m_active) begin
        if (run && mask != '0) begin
          m_active = 1'b1; m_ch = lowest(mask); m_pos = 0;
        end
      end else if (m_pos < S) begin
        m_pos++;
      end else if (m_pos == S) begin
        if (m_s2[m_ch] != m_det[m_ch]) begin
          m_cnt[m_ch]++;
          if (m_cnt[m_ch] >= DEB) begin
            m_det[m_ch] = m_s2[m_ch];
            m_cnt[m_ch] = 0;
            m_chg = 1'b1;
          end
        end else begin
          m_cnt[m_ch] = 0;
        end
        m_pos = S + 1;
      end else begin
        nxt = next_above(mask, m_ch);
        if (mask == '0 || !run) m_active = 1'b0;
        else if (nxt >= 0) begin m_ch = nxt; m_pos = 0; end
        else begin m_ch = lowest(mask); m_pos = 0; end
      end
      m_s2 = m_s1;
      m_s1 = pin;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_en;
    bit           exp_sd;
    if (chk_on) begin
      exp_en = (m_active && m_pos <= S) ? N'(1 << m_ch) : '0;
      exp_sd = m_active && (m_pos == S + 1) && (mask != '0) && (next_above(mask, m_ch) < 0);
      chk("enable", enable, exp_en);
      chk("detect", detect, m_det);
      chk("changed", changed, m_chg);
      chk("scan_done", scan_done, exp_sd);
      chk("busy", busy, m_active);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_enable(input logic [N-1:0] want, input string tag);
    int k;
    k = 0;
    while (enable !== want && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) chk(tag, enable, want);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mask = '0; pin = '0;
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    step(20);
    chk("idle_busy", busy, 1'b0);
    run = 1'b1;
    step(5);
    chk("empty_mask_busy", busy, 1'b0);

    mask = 4'b1011;
    step(40);

    // Single-scan glitch on channel 1: exactly one sample sees it.
    pin[1] = 1'b1;
    step(18);
    pin[1] = 1'b0;
    step(40);
    chk("glitch_detect1", detect[1], 1'b0);
    pin[1] = 1'b1;
    step(40);
    chk("held_detect1", detect[1], 1'b1);

    pin[3] = 1'b1;
    step(60);
    chk("detect3_set", detect[3], 1'b1);
    mask = 4'b0011;
    pin[3] = 1'b0;
    step(100);
    chk("masked_hold3", detect[3], 1'b1);

    wait_enable(4'b0010, "wait_ch1");
    run = 1'b0;
    step(20);
    chk("stop_busy", busy, 1'b0);
    chk("stop_enable", enable, 4'b0000);

    mask = 4'b1011;
    run = 1'b1;
    step(20);
    wait_enable(4'b0001, "wait_ch0");
    step();
    rst = 1'b1;
    step();
    chk("rst_enable", enable, 4'b0000);
    chk("rst_detect", detect, 4'b0000);
    rst = 1'b0;
    step(30);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) pin[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(99) == 0) mask = N'($urandom);
      if ($urandom_range(59) == 0) run = ($urandom_range(7) != 0);
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
